// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline (master) and the stall/flush sequencer (slave).
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             load_use_i;
  logic             branch_taken_i;
  logic             dcache_miss_i;
  logic             mem_ack_i;
  logic             mul_start_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_en_o;
  logic             mem_req_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output load_use_i, branch_taken_i, dcache_miss_i, mem_ack_i, mul_start_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_en_o,
           mem_req_o, stall_cnt_o
  );

  modport slave (
    input  load_use_i, branch_taken_i, dcache_miss_i, mem_ack_i, mul_start_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_en_o,
           mem_req_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch flush,
// D-cache miss and multi-cycle mul/div freezes; counts stalled cycles.
module pipeline_stall_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_stall_ctrl_if.slave  ctl
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MUL_BUSY
  } state_t;

  state_t           state, stateNext;
  logic [5:0]       mulCnt, mulCntNext;
  logic             memReq, memReqNext;
  logic [CNT_W-1:0] stallCnt;

  logic pcWrite, ifidWrite, ifidFlush, idexBubble, pipeEn;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= RUN;
      mulCnt <= '0;
      memReq <= 1'b0;
    end else begin
      state  <= stateNext;
      mulCnt <= mulCntNext;
      memReq <= memReqNext;
    end
  end

  always_comb begin
    stateNext  = state;
    mulCntNext = mulCnt;
    memReqNext = memReq;
    pcWrite    = 1'b0;
    ifidWrite  = 1'b0;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    pipeEn     = 1'b0;
    unique case (state)
      RUN: begin
        if (ctl.dcache_miss_i) begin
          stateNext  = MEM_WAIT;
          memReqNext = 1'b1;
        end else if (ctl.mul_start_i) begin
          // A single-cycle op needs only this cycle's freeze, so stay in RUN.
          if (MUL_CYCLES > 1) begin
            stateNext  = MUL_BUSY;
            mulCntNext = 6'(MUL_CYCLES - 1);
          end
        end else if (ctl.load_use_i) begin
          idexBubble = 1'b1;
          pipeEn     = 1'b1;
        end else begin
          pcWrite   = 1'b1;
          ifidWrite = 1'b1;
          pipeEn    = 1'b1;
          ifidFlush = ctl.branch_taken_i;
        end
      end
      MEM_WAIT: begin
        if (ctl.mem_ack_i) begin
          memReqNext = 1'b0;
          stateNext  = RUN;
        end
      end
      MUL_BUSY: begin
        mulCntNext = mulCnt - 6'd1;
        if (mulCnt <= 6'd1) begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  // Counter uses the ungated PC enable; reset clears it asynchronously anyway.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCnt <= '0;
    end else if (!pcWrite && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign ctl.pc_write_o    = pcWrite    & ~rst_i;
  assign ctl.ifid_write_o  = ifidWrite  & ~rst_i;
  assign ctl.ifid_flush_o  = ifidFlush  & ~rst_i;
  assign ctl.idex_bubble_o = idexBubble & ~rst_i;
  assign ctl.pipe_en_o     = pipeEn     & ~rst_i;
  assign ctl.mem_req_o     = memReq;
  assign ctl.stall_cnt_o   = stallCnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus randomized run against a
// cycle-level reference model (two instances: defaults, and CNT_W=4/MUL_CYCLES=1).
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_stall_ctrl_if #(.CNT_W(4))  bus4 ();

  pipeline_stall_ctrl #(.MUL_CYCLES(4), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ctl   (bus)
  );

  pipeline_stall_ctrl #(.MUL_CYCLES(1), .CNT_W(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .ctl   (bus4)
  );

  // {pc_write, ifid_write, pipe_en, ifid_flush, idex_bubble}
  logic [4:0] outs, outs4;
  assign outs  = {bus.pc_write_o, bus.ifid_write_o, bus.pipe_en_o, bus.ifid_flush_o, bus.idex_bubble_o};
  assign outs4 = {bus4.pc_write_o, bus4.ifid_write_o, bus4.pipe_en_o, bus4.ifid_flush_o, bus4.idex_bubble_o};

  task automatic clear_inputs();
    bus.load_use_i = 0; bus.branch_taken_i = 0; bus.dcache_miss_i = 0;
    bus.mem_ack_i = 0; bus.mul_start_i = 0;
    bus4.load_use_i = 0; bus4.branch_taken_i = 0; bus4.dcache_miss_i = 0;
    bus4.mem_ack_i = 0; bus4.mul_start_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.branch_taken_i = 1;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00000) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", outs, 5'b00000); end
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.stall_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_regs got req=%b cnt=%0d exp req=0 cnt=0", bus.mem_req_o, bus.stall_cnt_o);
    end
    tick();
    rst = 1'b0;
    bus.branch_taken_i = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (outs !== 5'b11100 || bus.mem_req_o !== 1'b0 || bus.stall_cnt_o !== 16'd0) begin
        errors++;
        $display("FAIL idle_run c=%0d got=%b req=%b cnt=%0d exp=11100 req=0 cnt=0", c, outs, bus.mem_req_o, bus.stall_cnt_o);
      end
      tick();
    end
  endtask

  task automatic test_load_use_branch();
    do_reset();
    bus.load_use_i = 1; bus.branch_taken_i = 1;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00101) begin errors++; $display("FAIL lu_over_branch got=%b exp=%b", outs, 5'b00101); end
    tick();
    bus.load_use_i = 0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11110 || bus.stall_cnt_o !== 16'd1) begin
      errors++; $display("FAIL branch_flush got=%b cnt=%0d exp=11110 cnt=1", outs, bus.stall_cnt_o);
    end
    tick();
    bus.branch_taken_i = 0;
  endtask

  task automatic test_miss();
    logic [4:0] e;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      bus.dcache_miss_i = (c <= 4);
      bus.mem_ack_i     = (c == 4);
      e = (c <= 4) ? 5'b00000 : 5'b11100;
      @(negedge clk);
      checks++;
      if (outs !== e || bus.mem_req_o !== (c >= 1 && c <= 4)) begin
        errors++; $display("FAIL miss c=%0d got=%b req=%b exp=%b req=%b", c, outs, bus.mem_req_o, e, (c >= 1 && c <= 4));
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.stall_cnt_o !== 16'd5) begin errors++; $display("FAIL miss_cnt got=%0d exp=5", bus.stall_cnt_o); end
    tick();
  endtask

  task automatic test_mul();
    logic [4:0] e, e4;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      bus.mul_start_i = (c == 0);  bus.load_use_i  = (c <= 4);
      bus4.mul_start_i = (c == 0); bus4.load_use_i = (c <= 4);
      e  = (c <= 3) ? 5'b00000 : (c == 4) ? 5'b00101 : 5'b11100;
      e4 = (c == 0) ? 5'b00000 : (c <= 4) ? 5'b00101 : 5'b11100;
      @(negedge clk);
      checks++;
      if (outs !== e) begin errors++; $display("FAIL mul4 c=%0d got=%b exp=%b", c, outs, e); end
      checks++;
      if (outs4 !== e4) begin errors++; $display("FAIL mul1 c=%0d got=%b exp=%b", c, outs4, e4); end
      if (c == 5) begin
        checks++;
        if (bus.stall_cnt_o !== 16'd5 || bus4.stall_cnt_o !== 4'd5) begin
          errors++; $display("FAIL mul_cnt got=%0d/%0d exp=5/5", bus.stall_cnt_o, bus4.stall_cnt_o);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    bus.dcache_miss_i = 1;
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL midmiss_req got=%b exp=1", bus.mem_req_o); end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.stall_cnt_o !== 16'd0 || outs !== 5'b00000) begin
      errors++; $display("FAIL async_rst got req=%b cnt=%0d outs=%b exp req=0 cnt=0 outs=00000", bus.mem_req_o, bus.stall_cnt_o, outs);
    end
    bus.dcache_miss_i = 0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.mem_ack_i = 1;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11100 || bus.mem_req_o !== 1'b0) begin
      errors++; $display("FAIL stale_ack got=%b req=%b exp=11100 req=0", outs, bus.mem_req_o);
    end
    tick();
    bus.mem_ack_i = 0;
    @(negedge clk);
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.stall_cnt_o !== 16'd0) begin
      errors++; $display("FAIL post_rst got req=%b cnt=%0d exp req=0 cnt=0", bus.mem_req_o, bus.stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_saturate();
    int e;
    do_reset();
    bus4.dcache_miss_i = 1;
    for (int i = 0; i <= 20; i++) begin
      e = (i < 15) ? i : 15;
      @(negedge clk);
      checks++;
      if (bus4.stall_cnt_o !== 4'(e) || outs4[4] !== 1'b0) begin
        errors++; $display("FAIL saturate i=%0d got=%0d pc=%b exp=%0d pc=0", i, bus4.stall_cnt_o, outs4[4], e);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int         mBusy[2], mCnt[2], cmax[2], mc[2];
    bit         mMiss[2];
    logic [4:0] eo[2];
    logic       er[2];
    int         ec[2];
    bit         lu, br, ms, ak, mu;
    do_reset();
    cmax[0] = 65535; cmax[1] = 15; mc[0] = 4; mc[1] = 1;
    for (int k = 0; k < 2; k++) begin mBusy[k] = 0; mCnt[k] = 0; mMiss[k] = 0; end
    for (int c = 0; c < 500; c++) begin
      lu = ($urandom_range(0, 99) < 25);
      br = ($urandom_range(0, 99) < 30);
      ms = ($urandom_range(0, 99) < 10);
      ak = ($urandom_range(0, 99) < 30);
      mu = ($urandom_range(0, 99) < 10);
      bus.load_use_i = lu;  bus.branch_taken_i = br;  bus.dcache_miss_i = ms;
      bus.mem_ack_i = ak;   bus.mul_start_i = mu;
      bus4.load_use_i = lu; bus4.branch_taken_i = br; bus4.dcache_miss_i = ms;
      bus4.mem_ack_i = ak;  bus4.mul_start_i = mu;
      for (int k = 0; k < 2; k++) begin
        er[k] = mMiss[k];
        ec[k] = mCnt[k];
        if (mMiss[k]) begin
          eo[k] = 5'b00000;
          if (ak) mMiss[k] = 0;
        end else if (mBusy[k] > 0) begin
          eo[k] = 5'b00000;
          mBusy[k]--;
        end else if (ms) begin
          eo[k] = 5'b00000;
          mMiss[k] = 1;
        end else if (mu) begin
          eo[k] = 5'b00000;
          mBusy[k] = mc[k] - 1;
        end else if (lu) begin
          eo[k] = 5'b00101;
        end else begin
          eo[k] = br ? 5'b11110 : 5'b11100;
        end
        if (!eo[k][4] && mCnt[k] < cmax[k]) mCnt[k]++;
      end
      @(negedge clk);
      checks++;
      if (outs !== eo[0] || bus.mem_req_o !== er[0] || bus.stall_cnt_o !== 16'(ec[0])) begin
        errors++;
        $display("FAIL rand_main c=%0d got=%b req=%b cnt=%0d exp=%b req=%b cnt=%0d",
                 c, outs, bus.mem_req_o, bus.stall_cnt_o, eo[0], er[0], ec[0]);
      end
      checks++;
      if (outs4 !== eo[1] || bus4.mem_req_o !== er[1] || bus4.stall_cnt_o !== 4'(ec[1])) begin
        errors++;
        $display("FAIL rand_small c=%0d got=%b req=%b cnt=%0d exp=%b req=%b cnt=%0d",
                 c, outs4, bus4.mem_req_o, bus4.stall_cnt_o, eo[1], er[1], ec[1]);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use_branch();
    test_miss();
    test_mul();
    test_reset_mid_miss();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
